sample_buf_ram: RTL and testbench

- Parametrised single-clock buffer RAM that succeeds the fixed 4096x16 simple dual-port BRAM.
- Two runtime modes:
  - FIFO: streaming UART/MATLAB sample frames, with full/empty/count flags and ready/valid-style handshake.
  - Random-access: addressed write and read, as the BRAM did.
- Sits between the UART byte assembler and the processing datapath.

---
 rtl/sample_buf_pkg.sv | 13 +
 rtl/sample_buf_mem.sv | 34 +++
 rtl/sample_buf_ram.sv | 133 +++++++++++++
 tb/tb_sample_buf_ram.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_buf_pkg.sv
// Shared FSM state and mode encodings for the sample buffer RAM.
package sample_buf_pkg;

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_FIFO  = 2'd1,
        S_RAND  = 2'd2
    } state_t;

    localparam logic MODE_FIFO = 1'b0;
    localparam logic MODE_RAND = 1'b1;

endpackage

// File: rtl/sample_buf_mem.sv
// Simple dual-port array with one write port and a registered read-first read port.
// The array itself has no reset so it stays inferable as block RAM.
module sample_buf_mem #(
    parameter int WIDTH = 16,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reading the array with a non-blocking update alongside the write gives read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_buf_ram.sv
// Single-clock sample buffer: FIFO or random-access selected at runtime by mode.
// Define SAMPLE_BUF_PARITY_EN to store an even-parity bit per word and report par_err.
module sample_buf_ram
    import sample_buf_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int AFULL_LVL = 2**ADDR_W - 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              flush,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              afull,
    output logic [ADDR_W:0]   count
`ifdef SAMPLE_BUF_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

`ifdef SAMPLE_BUF_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t            state;
    logic [ADDR_W-1:0] wptr, rptr;
    logic              in_fifo, in_rand, active;
    logic              wr_fire, rd_fire, fifo_wr, fifo_rd;
    logic [ADDR_W:0]   count_nxt;
    logic [MEM_W-1:0]  mem_wdata, mem_rdata;

    // Accesses only happen when the running state still matches mode and no flush is asked for.
    assign in_fifo  = (state == S_FIFO) && (mode == MODE_FIFO);
    assign in_rand  = (state == S_RAND) && (mode == MODE_RAND);
    assign active   = (in_fifo || in_rand) && !flush;
    assign wr_ready = active && (in_rand || !full);
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = active && rd_req && (in_rand || !empty);
    assign fifo_wr  = wr_fire && in_fifo;
    assign fifo_rd  = rd_fire && in_fifo;

    always_comb begin
        count_nxt = count;
        if (fifo_wr && !fifo_rd) begin
            count_nxt = count + CNT_ONE;
        end else if (fifo_rd && !fifo_wr) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Leaving a mode clears pointers right away; S_FLUSH then picks the next mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FLUSH;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            afull    <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (!active) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
                full  <= 1'b0;
                empty <= 1'b1;
                afull <= 1'b0;
                if (state == S_FLUSH) begin
                    state <= (mode == MODE_RAND) ? S_RAND : S_FIFO;
                end else begin
                    state <= S_FLUSH;
                end
            end else if (in_fifo) begin
                if (fifo_wr) begin
                    wptr <= wptr + PTR_ONE;
                end
                if (fifo_rd) begin
                    rptr <= rptr + PTR_ONE;
                end
                count <= count_nxt;
                full  <= (count_nxt == FULL_CNT);
                empty <= (count_nxt == '0);
                afull <= (count_nxt >= AFULL_CNT);
            end
        end
    end

`ifdef SAMPLE_BUF_PARITY_EN
    assign mem_wdata = {^wr_data, wr_data};
    assign rd_data   = mem_rdata[DATA_W-1:0];
    assign par_err   = rd_valid && (^mem_rdata);
`else
    assign mem_wdata = wr_data;
    assign rd_data   = mem_rdata;
`endif

    sample_buf_mem #(
        .WIDTH (MEM_W),
        .AW    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire),
        .waddr (in_rand ? wr_addr : wptr),
        .wdata (mem_wdata),
        .re    (rd_fire),
        .raddr (in_rand ? rd_addr : rptr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_sample_buf_ram.sv
// Scoreboard bench for sample_buf_ram: queue/array reference model, decoupled read monitor.
module tb_sample_buf_ram;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 12;
    localparam int DEPTH     = 4096;
    localparam int AFULL_LVL = DEPTH - 16;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
`ifdef SAMPLE_BUF_PARITY_EN
        logic              perr;
`endif
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mode = 1'b0;
    logic              flush = 1'b0;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              wr_ready, rd_valid, full, empty, afull;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
`ifdef SAMPLE_BUF_PARITY_EN
    logic              par_err;
    logic              expect_perr = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    exp_t              exp_q[$];
    exp_t              mon_e;
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] ram_model [DEPTH];
    bit                fsm_mode = 1'b0;
    bit                flushing = 1'b1;

    sample_buf_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .afull    (afull),
        .count    (count)
`ifdef SAMPLE_BUF_PARITY_EN
        ,
        .par_err  (par_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cycle);
        end
    endfunction

    // One clock of stimulus; the model decides acceptance from its own occupancy and mode history.
    task automatic applyStimulus(input logic md, input logic fl, input logic wv, input logic [DATA_W-1:0] wd,
                                 input logic [ADDR_W-1:0] wa, input logic rr, input logic [ADDR_W-1:0] ra);
        logic acc, exp_rdy, w_ok, r_ok;
        int   exp_cnt;
        exp_t e;
        mode = md; flush = fl; wr_valid = wv; wr_data = wd; wr_addr = wa; rd_req = rr; rd_addr = ra;
        acc     = !flushing && !fl && (md == fsm_mode);
        exp_rdy = acc && (fsm_mode || model_q.size() < DEPTH);
        w_ok    = exp_rdy && wv;
        r_ok    = acc && rr && (fsm_mode || model_q.size() > 0);
        #1;
        checkOutput("wr_ready", 32'(wr_ready), 32'(exp_rdy));
        if (r_ok) begin
            e.data = fsm_mode ? ram_model[ra] : model_q.pop_front();
            e.cyc  = cycle + 1;
`ifdef SAMPLE_BUF_PARITY_EN
            e.perr = expect_perr;
`endif
            exp_q.push_back(e);
        end
        if (w_ok) begin
            if (fsm_mode) ram_model[wa] = wd;
            else model_q.push_back(wd);
        end
        if (flushing) begin
            flushing = 1'b0;
            fsm_mode = md;
        end else if (fl || md != fsm_mode) begin
            flushing = 1'b1;
            model_q.delete();
        end
        @(posedge clk);
        #1;
        exp_cnt = fsm_mode ? 0 : model_q.size();
        checkOutput("count", 32'(count), 32'(exp_cnt));
        checkOutput("empty", 32'(empty), 32'(exp_cnt == 0));
        checkOutput("full",  32'(full),  32'(exp_cnt == DEPTH));
        checkOutput("afull", 32'(afull), 32'(exp_cnt >= AFULL_LVL));
    endtask

    task automatic idle(input logic md, input int n);
        for (int i = 0; i < n; i++) applyStimulus(md, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected rd_valid", 32'(rd_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("rd_data", 32'(rd_data), 32'(mon_e.data));
                    checkOutput("rd latency", 32'(cycle), 32'(mon_e.cyc));
`ifdef SAMPLE_BUF_PARITY_EN
                    checkOutput("par_err", 32'(par_err), 32'(mon_e.perr));
`endif
                end
            end
`ifdef SAMPLE_BUF_PARITY_EN
            else begin
                checkOutput("par_err idle", 32'(par_err), 32'd0);
            end
`endif
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #12;
        checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset rd_data",  32'(rd_data),  32'd0);
        checkOutput("reset count",    32'(count),    32'd0);
        checkOutput("reset empty",    32'(empty),    32'd1);
        checkOutput("reset full",     32'(full),     32'd0);
        checkOutput("reset afull",    32'(afull),    32'd0);
        checkOutput("reset wr_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        idle(1'b0, 1);

        // Fill to full, then a read+write while full, then drain.
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(i), '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hDEAD, '0, 1'b1, '0);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
        idle(1'b0, 1);

        // Read while empty with a concurrent write.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, '0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
        idle(1'b0, 1);

        // Pointer wrap.
        for (int i = 0; i < 4000; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(i), '0, 1'b0, '0);
        for (int i = 0; i < 4000; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(16'hA000 + i), '0, 1'b0, '0);
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);

        // Random FIFO traffic.
        for (int i = 0; i < 2000; i++)
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom()),
                          ADDR_W'($urandom()), 1'($urandom_range(0, 1)), ADDR_W'($urandom()));
        while (model_q.size() > 0) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);

        // Mode change with ten words stored; writes offered during the switch must be refused.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(16'h0100 + i), '0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h1111, 12'h7FF, 1'b1, 12'h7FF);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h2222, 12'h7FF, 1'b1, 12'h7FF);

        // Random-access, read-first collision.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234, 12'h7FF, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 12'h7FF);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h5678, 12'h7FF, 1'b1, 12'h7FF);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 12'h7FF);
        for (int a = 0; a < 32; a++) applyStimulus(1'b1, 1'b0, 1'b1, DATA_W'($urandom()), ADDR_W'(a), 1'b0, '0);
        for (int i = 0; i < 1000; i++)
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom()),
                          ADDR_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)));

`ifdef SAMPLE_BUF_PARITY_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h00F0, 12'h100, 1'b0, '0);
        dut.u_mem.mem[12'h100] = dut.u_mem.mem[12'h100] ^ 17'h00008;
        ram_model[12'h100] = 16'h00F8;
        expect_perr = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 12'h100);
        expect_perr = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 12'h7FF);
`endif

        // Back to FIFO, then a flush pulse with five words stored.
        idle(1'b0, 2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(16'h0500 + i), '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h3333, '0, 1'b1, '0);
        idle(1'b0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(16'h0700 + i), '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);

        // Reset while a read result is being presented.
        checkOutput("rd_valid before reset", 32'(rd_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rd_valid in reset", 32'(rd_valid), 32'd0);
        checkOutput("rd_data in reset",  32'(rd_data),  32'd0);
        checkOutput("count in reset",    32'(count),    32'd0);
        checkOutput("empty in reset",    32'(empty),    32'd1);
        checkOutput("wr_ready in reset", 32'(wr_ready), 32'd0);
        exp_q.delete();
        model_q.delete();
        flushing = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        idle(1'b0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(16'h0900 + i), '0, 1'b1, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
        idle(1'b0, 3);
        checkOutput("outstanding reads", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
